// File: rtl/tpu_job_sequencer.sv
// Job sequencer in front of the tpuv1 matrix unit.
// Streams A and B operand rows onto the TPU bus, optionally zeroes C, fires the
// start command, waits out the systolic run, and returns C half-rows on a
// valid/ready result stream.
module tpu_job_sequencer #(
   parameter int DIM      = 8,
   parameter int DATAW    = 64,
   parameter int ADDRW    = 16,
   parameter int WAIT_CYC = 3 * DIM,
   parameter int RD_LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_start_i,
   input  logic             job_clear_c_i,
   output logic             busy_o,
   output logic             job_done_o,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [DATAW-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DATAW-1:0] out_data_o,
   output logic             tpu_r_w_o,
   output logic [ADDRW-1:0] tpu_addr_o,
   output logic [DATAW-1:0] tpu_din_o,
   input  logic [DATAW-1:0] tpu_dout_i
);

   localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int JW = $clog2(2 * DIM);
   localparam int WW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
   localparam int RW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

   localparam logic [ADDRW-1:0] A_BASE = ADDRW'(16'h0100);
   localparam logic [ADDRW-1:0] B_BASE = ADDRW'(16'h0200);
   localparam logic [ADDRW-1:0] C_BASE = ADDRW'(16'h0300);
   localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_CLR_C,
      S_START,
      S_WAIT,
      S_READ_C,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic [JW-1:0]    j_q;
   logic [WW-1:0]    wait_q;
   logic [RW-1:0]    rd_q;
   logic             clear_c_q;
   logic             out_valid_q;
   logic [DATAW-1:0] out_data_q;

   logic             in_hs;
   logic [ADDRW-1:0] k_off;
   logic [ADDRW-1:0] j_off;

   // Operand words are only taken while loading A or B; rows are 8 bytes apart.
   assign in_ready_o  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign in_hs       = in_valid_i && in_ready_o;
   assign k_off       = ADDRW'(k_q) << 3;
   assign j_off       = ADDRW'(j_q) << 3;
   assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign job_done_o  = (state_q == S_DONE);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   // Job sequencing: state, row counters, wait timer and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         j_q         <= '0;
         wait_q      <= '0;
         rd_q        <= '0;
         clear_c_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (job_start_i) begin
                  clear_c_q <= job_clear_c_i;
                  k_q       <= '0;
                  state_q   <= S_LOAD_A;
               end
            end
            S_LOAD_A: begin
               if (in_hs) begin
                  if (k_q == KW'(DIM - 1)) begin
                     k_q     <= '0;
                     state_q <= S_LOAD_B;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            S_LOAD_B: begin
               if (in_hs) begin
                  if (k_q == KW'(DIM - 1)) begin
                     k_q     <= '0;
                     j_q     <= '0;
                     state_q <= clear_c_q ? S_CLR_C : S_START;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            S_CLR_C: begin
               if (j_q == JW'(2 * DIM - 1)) begin
                  j_q     <= '0;
                  state_q <= S_START;
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end
            S_START: begin
               wait_q  <= WW'(WAIT_CYC - 1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_q == '0) begin
                  j_q         <= '0;
                  rd_q        <= '0;
                  out_valid_q <= 1'b0;
                  state_q     <= S_READ_C;
               end else begin
                  wait_q <= wait_q - 1'b1;
               end
            end
            S_READ_C: begin
               // The read address stays put until its word has been handed off.
               if (out_valid_q) begin
                  if (out_ready_i) begin
                     out_valid_q <= 1'b0;
                     rd_q        <= '0;
                     if (j_q == JW'(2 * DIM - 1)) begin
                        j_q     <= '0;
                        state_q <= S_DONE;
                     end else begin
                        j_q <= j_q + 1'b1;
                     end
                  end
               end else if (rd_q == RW'(RD_LAT)) begin
                  out_data_q  <= tpu_dout_i;
                  out_valid_q <= 1'b1;
               end else begin
                  rd_q <= rd_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // TPU bus drive: operand writes pass straight through, everything else follows state.
   always_comb begin
      tpu_r_w_o  = 1'b0;
      tpu_addr_o = '0;
      tpu_din_o  = '0;
      case (state_q)
         S_LOAD_A: begin
            if (in_hs) begin
               tpu_r_w_o  = 1'b1;
               tpu_addr_o = A_BASE + k_off;
               tpu_din_o  = in_data_i;
            end
         end
         S_LOAD_B: begin
            if (in_hs) begin
               tpu_r_w_o  = 1'b1;
               tpu_addr_o = B_BASE + k_off;
               tpu_din_o  = in_data_i;
            end
         end
         S_CLR_C: begin
            tpu_r_w_o  = 1'b1;
            tpu_addr_o = C_BASE + j_off;
         end
         S_START: begin
            tpu_r_w_o  = 1'b1;
            tpu_addr_o = START_ADDR;
         end
         S_READ_C: begin
            tpu_addr_o = C_BASE + j_off;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Bench for tpu_job_sequencer: a small TPU memory model sits on the bus, a bus
// monitor and a result monitor pop expected traffic queued when each job is issued.
`timescale 1ns/1ps
module tb_tpu_job_sequencer;

   logic        clk;
   logic        rst_n;
   logic        job_start;
   logic        job_clear_c;
   logic        busy;
   logic        job_done;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        tpu_r_w;
   logic [15:0] tpu_addr;
   logic [63:0] tpu_din;
   logic [63:0] tpu_dout;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int res_seen = 0;
   bit stall_req = 0;

   logic [80:0] bus_q[$];
   logic [63:0] res_q[$];
   logic [63:0] opa[8];
   logic [63:0] opb[8];

   logic [63:0] amem[8];
   logic [63:0] bmem[8];
   int          cm[8][8];

   tpu_job_sequencer #(.DIM(8), .DATAW(64), .ADDRW(16), .WAIT_CYC(24), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .job_start_i  (job_start),
      .job_clear_c_i(job_clear_c),
      .busy_o       (busy),
      .job_done_o   (job_done),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .tpu_r_w_o    (tpu_r_w),
      .tpu_addr_o   (tpu_addr),
      .tpu_din_o    (tpu_din),
      .tpu_dout_i   (tpu_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input logic [80:0] act, input logic [80:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- TPU model ----------------
   function automatic int dot(input int i, input int e);
      int s;
      s = 0;
      for (int k = 0; k < 8; k++)
         s += int'($signed(amem[i][8*k +: 8])) * int'($signed(bmem[k][8*e +: 8]));
      return s;
   endfunction

   function automatic logic [63:0] pack_c(input logic [3:0] w);
      logic [63:0] r;
      int row, h;
      row = int'(w[3:1]);
      h   = int'(w[0]);
      r   = '0;
      for (int l = 0; l < 4; l++) r[16*l +: 16] = 16'(cm[row][4*h + l]);
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) begin
         amem[i] = '0;
         bmem[i] = '0;
         for (int e = 0; e < 8; e++) cm[i][e] = 0;
      end
   end

   always @(posedge clk) begin
      if (tpu_r_w) begin
         if (tpu_addr[15:8] == 8'h01) amem[tpu_addr[5:3]] <= tpu_din;
         else if (tpu_addr[15:8] == 8'h02) bmem[tpu_addr[5:3]] <= tpu_din;
         else if (tpu_addr[15:8] == 8'h03) begin
            for (int l = 0; l < 4; l++)
               cm[tpu_addr[6:4]][4*int'(tpu_addr[3]) + l] <= int'($signed(tpu_din[16*l +: 16]));
         end else if (tpu_addr == 16'h0400) begin
            for (int i = 0; i < 8; i++)
               for (int e = 0; e < 8; e++) cm[i][e] <= cm[i][e] + dot(i, e);
         end
      end
      tpu_dout <= (!tpu_r_w && tpu_addr[15:8] == 8'h03) ? pack_c(tpu_addr[6:3]) : 64'h0;
   end

   // ---------------- expected values ----------------
   // mode 1: C = B with B row r all (r+1); mode 2: previous C plus 1; mode 4: C[i][e] = 2*(i-e)
   function automatic logic [63:0] exp_word(input int mode, input int w);
      logic [63:0] r;
      int i, e, v;
      r = '0;
      i = w >> 1;
      for (int l = 0; l < 4; l++) begin
         e = 4 * (w % 2) + l;
         case (mode)
            1:       v = i + 1;
            2:       v = i + 2;
            default: v = 2 * (i - e);
         endcase
         r[16*l +: 16] = 16'(v);
      end
      return r;
   endfunction

   task automatic set_ops(input int mode);
      for (int r = 0; r < 8; r++) begin
         opa[r] = '0;
         opb[r] = '0;
         opa[r][8*r +: 8] = (mode == 4) ? 8'h02 : 8'h01;
         for (int e = 0; e < 8; e++) begin
            case (mode)
               1:       opb[r][8*e +: 8] = 8'(r + 1);
               4:       opb[r][8*e +: 8] = 8'(r - e);
               default: opb[r][8*e +: 8] = 8'h01;
            endcase
         end
      end
   endtask

   // ---------------- bus monitor ----------------
   logic        mon_prev_rd;
   logic [15:0] mon_prev_addr;
   bit          mon_armed;
   int          mon_gap;
   logic [80:0] mon_exp;

   initial begin
      mon_prev_rd = 1'b0; mon_prev_addr = '0; mon_armed = 0; mon_gap = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_armed   = 0;
            mon_prev_rd = 1'b0;
         end else if (tpu_r_w || tpu_addr != 16'h0) begin
            if (tpu_r_w || !(mon_prev_rd && mon_prev_addr == tpu_addr)) begin
               if (mon_armed) begin
                  check_eq("wait_idle_cycles", 81'(mon_gap), 81'(24));
                  mon_armed = 0;
               end
               if (bus_q.size() == 0) begin
                  check_eq("bus_extra_event", {tpu_r_w, tpu_addr, tpu_din}, 81'h0);
               end else begin
                  mon_exp = bus_q.pop_front();
                  check_eq("bus_event", {tpu_r_w, tpu_addr, tpu_din}, mon_exp);
               end
               if (tpu_r_w && tpu_addr == 16'h0400) begin
                  mon_armed = 1;
                  mon_gap   = 0;
               end
            end
            mon_prev_rd   = !tpu_r_w;
            mon_prev_addr = tpu_addr;
         end else begin
            mon_prev_rd = 1'b0;
            if (mon_armed) mon_gap++;
         end
      end
   end

   // ---------------- result monitor ----------------
   logic [63:0] res_exp;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (res_q.size() == 0) begin
               check_eq("result_extra", 81'(out_data), 81'h0);
            end else begin
               res_exp = res_q.pop_front();
               check_eq("result_word", 81'(out_data), 81'(res_exp));
            end
            res_seen++;
         end
      end
   end

   // ---------------- result consumer (back-pressure on result 3) ----------------
   logic [63:0] held;
   initial begin
      forever begin
         tick;
         if (stall_req && out_valid && res_seen == 3) begin
            held      = out_data;
            out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               check_eq("stall_hold", {out_valid, tpu_r_w, tpu_addr, out_data},
                        {1'b1, 1'b0, 16'h0318, held});
               tick;
            end
            out_ready = 1'b1;
            stall_req = 0;
         end
      end
   end

   // ---------------- job driver ----------------
   task automatic run_job(input bit clr, input bit bub, input bit poke, input bit abort,
                          input int mode, output int lat);
      int  start_cyc;
      bit  got;
      lat = 0;
      for (int k = 0; k < 8; k++) bus_q.push_back({1'b1, 16'h0100 + 16'(8 * k), opa[k]});
      for (int k = 0; k < 8; k++) bus_q.push_back({1'b1, 16'h0200 + 16'(8 * k), opb[k]});
      if (clr)
         for (int j = 0; j < 16; j++) bus_q.push_back({1'b1, 16'h0300 + 16'(8 * j), 64'h0});
      bus_q.push_back({1'b1, 16'h0400, 64'h0});
      if (!abort) begin
         for (int j = 0; j < 16; j++) begin
            bus_q.push_back({1'b0, 16'h0300 + 16'(8 * j), 64'h0});
            res_q.push_back(exp_word(mode, j));
         end
      end
      res_seen = 0;
      tick;
      job_start   = 1'b1;
      job_clear_c = clr;
      start_cyc   = cyc;
      tick;
      job_start   = 1'b0;
      job_clear_c = 1'b0;
      check_eq("busy_after_start", 81'(busy), 81'(1));
      for (int idx = 0; idx < 16; idx++) begin
         if (bub && idx < 8 && (idx % 2) == 1) begin
            in_valid = 1'b0;
            tick;
         end
         in_valid = 1'b1;
         in_data  = (idx < 8) ? opa[idx] : opb[idx - 8];
         got = 0;
         for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
               got = 1;
               tick;
               break;
            end
            tick;
         end
         if (!got) check_eq("operand_accept_timeout", 81'(idx), 81'(-1));
      end
      in_valid = 1'b0;
      in_data  = '0;
      if (poke) begin
         repeat (20) tick;
         job_start   = 1'b1;
         job_clear_c = 1'b1;
         tick;
         job_start   = 1'b0;
         job_clear_c = 1'b0;
         check_eq("busy_after_ignored_start", 81'(busy), 81'(1));
      end
      if (abort) begin
         repeat (22) tick;
         rst_n = 1'b0;
         #1;
         check_eq("reset_mid_job_busy", 81'(busy), 81'(0));
         check_eq("reset_mid_job_bus", {tpu_r_w, tpu_addr, tpu_din}, 81'h0);
         check_eq("reset_mid_job_pending", 81'(bus_q.size()), 81'(0));
         tick;
         rst_n = 1'b1;
         return;
      end
      got = 0;
      for (int t = 0; t < 2000; t++) begin
         if (job_done) begin
            got = 1;
            break;
         end
         tick;
      end
      if (!got) begin
         check_eq("job_done_timeout", 81'(0), 81'(1));
      end else begin
         lat = cyc - start_cyc;
         check_eq("busy_low_in_done", 81'(busy), 81'(0));
         check_eq("results_pending", 81'(res_q.size()), 81'(0));
         check_eq("bus_pending", 81'(bus_q.size()), 81'(0));
      end
   endtask

   // ---------------- main sequence ----------------
   int lat, lat5, lat6;
   initial begin
      rst_n = 1'b0; job_start = 1'b0; job_clear_c = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) tick;
      check_eq("reset_busy", 81'(busy), 81'(0));
      check_eq("reset_done", 81'(job_done), 81'(0));
      check_eq("reset_handshake", {in_ready, out_valid}, 81'(0));
      check_eq("reset_bus", {tpu_r_w, tpu_addr, tpu_din}, 81'h0);
      check_eq("reset_out_data", 81'(out_data), 81'h0);
      rst_n = 1'b1;
      tick;

      // operand offered while idle is left upstream and the bus stays quiet
      in_valid = 1'b1;
      in_data  = 64'hDEAD_BEEF_0123_4567;
      tick;
      check_eq("idle_no_accept", {in_ready, tpu_r_w, tpu_addr}, 81'h0);
      in_valid = 1'b0;
      in_data  = '0;

      // identity A, B rows 1..8, clear C, bubbles in LOAD_A, back-pressure on result 3
      set_ops(1);
      stall_req = 1;
      run_job(1'b1, 1'b1, 1'b0, 1'b0, 1, lat);
      check_eq("stall_consumed", 81'(stall_req), 81'(0));

      // no clear: C accumulates; stray job_start during WAIT
      set_ops(2);
      run_job(1'b0, 1'b0, 1'b1, 1'b0, 2, lat);
      check_eq("latency_no_clear", 81'(lat), 81'(90));
      repeat (5) tick;
      check_eq("idle_after_ignored_start", 81'(busy), 81'(0));

      // reset while waiting, then a fresh job with signed results
      set_ops(2);
      run_job(1'b1, 1'b0, 1'b0, 1'b1, 0, lat);
      set_ops(4);
      run_job(1'b1, 1'b0, 1'b0, 1'b0, 4, lat);
      check_eq("latency_after_reset", 81'(lat), 81'(106));

      // back-to-back jobs
      set_ops(4);
      run_job(1'b1, 1'b0, 1'b0, 1'b0, 4, lat5);
      run_job(1'b1, 1'b0, 1'b0, 1'b0, 4, lat6);
      check_eq("latency_b2b_first", 81'(lat5), 81'(106));
      check_eq("latency_b2b_second", 81'(lat6), 81'(106));

      repeat (5) tick;
      check_eq("final_idle", {busy, tpu_r_w, tpu_addr}, 81'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
